// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch stage, the memory stage, the arbiter and the
// downstream memory. Signal names keep their original port names.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned XLEN   = 32
);
  // fetch requester
  logic              i_inst_req;
  logic [ADDR_W-1:0] i_inst_addr;
  logic              o_inst_ack;
  logic [XLEN-1:0]   o_inst_data;
  logic              o_inst_err;
  // memory-stage requester
  logic              i_data_req;
  logic [ADDR_W-1:0] i_data_addr;
  logic [XLEN-1:0]   i_data_wdata;
  logic [2:0]        i_data_funct3;
  logic              i_data_rw;
  logic              o_data_ack;
  logic [XLEN-1:0]   o_data_rdata;
  logic              o_data_err;
  // downstream memory
  logic              o_mem_req;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [XLEN-1:0]   o_mem_wdata;
  logic [2:0]        o_mem_funct3;
  logic              o_mem_rw;
  logic              i_mem_ack;
  logic [XLEN-1:0]   i_mem_rdata;

  // arbiter side
  modport slave (
    input  i_inst_req, i_inst_addr,
    output o_inst_ack, o_inst_data, o_inst_err,
    input  i_data_req, i_data_addr, i_data_wdata, i_data_funct3, i_data_rw,
    output o_data_ack, o_data_rdata, o_data_err,
    output o_mem_req, o_mem_addr, o_mem_wdata, o_mem_funct3, o_mem_rw,
    input  i_mem_ack, i_mem_rdata
  );

  // requesters and memory side
  modport master (
    output i_inst_req, i_inst_addr,
    input  o_inst_ack, o_inst_data, o_inst_err,
    output i_data_req, i_data_addr, i_data_wdata, i_data_funct3, i_data_rw,
    input  o_data_ack, o_data_rdata, o_data_err,
    input  o_mem_req, o_mem_addr, o_mem_wdata, o_mem_funct3, o_mem_rw,
    output i_mem_ack, i_mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data access share one
// downstream port. Data has priority, bounded by a burst limit while a fetch
// waits. Each transaction is aborted with an error after TIMEOUT busy cycles.
// Requesters are expected to drop or replace their request in the cycle
// their ack pulse is visible; the arbiter may grant again on that edge.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned D_BURST = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0]      BURST_MAX = 4'(D_BURST);
  localparam logic [15:0]     WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [XLEN-1:0] ZERO_W    = '0;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t            state;
  logic [3:0]        burst_cnt;
  logic [15:0]       wait_cnt;
  logic              data_go;
  logic              inst_go;
  logic [ADDR_W-1:0] grant_addr;

  // Grant decision evaluated in IDLE
  always_comb begin
    data_go    = bus.i_data_req && (!bus.i_inst_req || (burst_cnt < BURST_MAX));
    inst_go    = !data_go && bus.i_inst_req;
    grant_addr = data_go ? bus.i_data_addr : bus.i_inst_addr;
  end

  // Arbitration FSM with registered outputs, burst and wait counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      burst_cnt        <= '0;
      wait_cnt         <= '0;
      bus.o_inst_ack   <= 1'b0;
      bus.o_inst_data  <= '0;
      bus.o_inst_err   <= 1'b0;
      bus.o_data_ack   <= 1'b0;
      bus.o_data_rdata <= '0;
      bus.o_data_err   <= 1'b0;
      bus.o_mem_req    <= 1'b0;
      bus.o_mem_addr   <= '0;
      bus.o_mem_wdata  <= '0;
      bus.o_mem_funct3 <= '0;
      bus.o_mem_rw     <= 1'b0;
    end else begin
      bus.o_inst_ack <= 1'b0;
      bus.o_inst_err <= 1'b0;
      bus.o_data_ack <= 1'b0;
      bus.o_data_err <= 1'b0;

      // burst count only tracks data grants made while a fetch is waiting
      if (!bus.i_inst_req)
        burst_cnt <= '0;
      else if (state == IDLE && inst_go)
        burst_cnt <= '0;
      else if (state == IDLE && data_go && burst_cnt < BURST_MAX)
        burst_cnt <= burst_cnt + 4'd1;

      unique case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (data_go) begin
            state            <= BUSY_D;
            bus.o_mem_req    <= 1'b1;
            bus.o_mem_addr   <= grant_addr;
            bus.o_mem_wdata  <= bus.i_data_wdata;
            bus.o_mem_funct3 <= bus.i_data_funct3;
            bus.o_mem_rw     <= bus.i_data_rw;
          end else if (inst_go) begin
            state            <= BUSY_I;
            bus.o_mem_req    <= 1'b1;
            bus.o_mem_addr   <= grant_addr;
            bus.o_mem_wdata  <= ZERO_W;
            bus.o_mem_funct3 <= 3'b010;
            bus.o_mem_rw     <= 1'b0;
          end
        end
        BUSY_I, BUSY_D: begin
          // a downstream ack beats a timeout landing on the same edge
          if (bus.i_mem_ack) begin
            state         <= IDLE;
            bus.o_mem_req <= 1'b0;
            if (state == BUSY_I) begin
              bus.o_inst_ack  <= 1'b1;
              bus.o_inst_data <= bus.i_mem_rdata;
            end else begin
              bus.o_data_ack   <= 1'b1;
              bus.o_data_rdata <= bus.i_mem_rdata;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state         <= IDLE;
            bus.o_mem_req <= 1'b0;
            if (state == BUSY_I) begin
              bus.o_inst_ack  <= 1'b1;
              bus.o_inst_err  <= 1'b1;
              bus.o_inst_data <= ZERO_W;
            end else begin
              bus.o_data_ack   <= 1'b1;
              bus.o_data_err   <= 1'b1;
              bus.o_data_rdata <= ZERO_W;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (D_BURST=4, TIMEOUT=8). Inputs are driven
// and outputs sampled on the falling edge.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .XLEN(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .XLEN(32), .D_BURST(4), .TIMEOUT(8)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_mem_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic respond(input logic [31:0] d);
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = d;
    @(negedge clk);
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = 32'hA5A5_5A5A;
  endtask

  task automatic test_reset;
    bus.i_inst_req = 1'b1; bus.i_inst_addr = 32'h40;
    bus.i_data_req = 1'b1; bus.i_data_addr = 32'h80;
    bus.i_mem_ack  = 1'b1;
    cyc(2);
    n_cmp++; if (bus.o_mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req: got %b want 0", bus.o_mem_req); end
    n_cmp++; if ({bus.o_inst_ack, bus.o_data_ack, bus.o_inst_err, bus.o_data_err} !== 4'b0) begin n_bad++; $display("FAIL rst_acks: got %b want 0000", {bus.o_inst_ack, bus.o_data_ack, bus.o_inst_err, bus.o_data_err}); end
    n_cmp++; if ({bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_funct3, bus.o_mem_rw} !== 68'b0) begin n_bad++; $display("FAIL rst_fields: got %h want 0", {bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_funct3, bus.o_mem_rw}); end
    bus.i_inst_req = 1'b0; bus.i_data_req = 1'b0; bus.i_mem_ack = 1'b0;
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_ack_idle;
    respond(32'h1234_5678);
    n_cmp++; if ({bus.o_inst_ack, bus.o_data_ack, bus.o_mem_req} !== 3'b000) begin n_bad++; $display("FAIL idle_ack: got %b want 000", {bus.o_inst_ack, bus.o_data_ack, bus.o_mem_req}); end
    cyc(1);
  endtask

  task automatic test_single_fetch;
    bit ok;
    bus.i_data_wdata = 32'hFFFF_FFFF; bus.i_data_funct3 = 3'b111; bus.i_data_rw = 1'b1;
    bus.i_inst_req = 1'b1; bus.i_inst_addr = 32'h100;
    wait_req(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL fetch_grant: got no o_mem_req want 1"); end
    n_cmp++; if (bus.o_mem_addr !== 32'h100) begin n_bad++; $display("FAIL fetch_addr: got %h want 00000100", bus.o_mem_addr); end
    n_cmp++; if ({bus.o_mem_funct3, bus.o_mem_rw} !== 4'b0100) begin n_bad++; $display("FAIL fetch_f3rw: got %b want 0100", {bus.o_mem_funct3, bus.o_mem_rw}); end
    n_cmp++; if (bus.o_mem_wdata !== 32'h0) begin n_bad++; $display("FAIL fetch_wdata: got %h want 0", bus.o_mem_wdata); end
    cyc(3);
    n_cmp++; if (bus.o_inst_ack !== 1'b0) begin n_bad++; $display("FAIL fetch_early_ack: got %b want 0", bus.o_inst_ack); end
    respond(32'h0050_0093);
    n_cmp++; if ({bus.o_inst_ack, bus.o_inst_err, bus.o_data_ack, bus.o_mem_req} !== 4'b1000) begin n_bad++; $display("FAIL fetch_ack: got %b want 1000", {bus.o_inst_ack, bus.o_inst_err, bus.o_data_ack, bus.o_mem_req}); end
    n_cmp++; if (bus.o_inst_data !== 32'h0050_0093) begin n_bad++; $display("FAIL fetch_data: got %h want 00500093", bus.o_inst_data); end
    bus.i_inst_req = 1'b0;
    cyc(1);
    n_cmp++; if ({bus.o_inst_ack, bus.o_mem_req} !== 2'b00) begin n_bad++; $display("FAIL fetch_pulse: got %b want 00", {bus.o_inst_ack, bus.o_mem_req}); end
    cyc(1);
  endtask

  task automatic test_simultaneous;
    bit ok;
    bus.i_inst_req = 1'b1; bus.i_inst_addr = 32'h200;
    bus.i_data_req = 1'b1; bus.i_data_addr = 32'h2000; bus.i_data_wdata = 32'hDEAD_BEEF;
    bus.i_data_funct3 = 3'b010; bus.i_data_rw = 1'b1;
    wait_req(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL sim_grant1: got no o_mem_req want 1"); end
    n_cmp++; if ({bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_funct3, bus.o_mem_rw} !== {32'h2000, 32'hDEAD_BEEF, 3'b010, 1'b1}) begin n_bad++; $display("FAIL sim_data_fields: got %h want %h", {bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_funct3, bus.o_mem_rw}, {32'h2000, 32'hDEAD_BEEF, 3'b010, 1'b1}); end
    respond(32'h0);
    n_cmp++; if ({bus.o_data_ack, bus.o_inst_ack} !== 2'b10) begin n_bad++; $display("FAIL sim_ack1: got %b want 10", {bus.o_data_ack, bus.o_inst_ack}); end
    bus.i_data_req = 1'b0;
    cyc(1);
    n_cmp++; if ({bus.o_mem_req, bus.o_data_ack, bus.o_inst_ack} !== 3'b100) begin n_bad++; $display("FAIL sim_grant2: got %b want 100", {bus.o_mem_req, bus.o_data_ack, bus.o_inst_ack}); end
    n_cmp++; if ({bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_funct3, bus.o_mem_rw} !== {32'h200, 32'h0, 3'b010, 1'b0}) begin n_bad++; $display("FAIL sim_inst_fields: got %h want %h", {bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_funct3, bus.o_mem_rw}, {32'h200, 32'h0, 3'b010, 1'b0}); end
    respond(32'h0000_0013);
    n_cmp++; if ({bus.o_data_ack, bus.o_inst_ack} !== 2'b01) begin n_bad++; $display("FAIL sim_ack2: got %b want 01", {bus.o_data_ack, bus.o_inst_ack}); end
    n_cmp++; if (bus.o_inst_data !== 32'h13) begin n_bad++; $display("FAIL sim_inst_data: got %h want 00000013", bus.o_inst_data); end
    bus.i_inst_req = 1'b0;
    cyc(2);
  endtask

  task automatic test_burst;
    bit ok;
    logic exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.i_inst_req = 1'b1; bus.i_inst_addr = 32'h400;
    bus.i_data_req = 1'b1; bus.i_data_addr = 32'h3000; bus.i_data_rw = 1'b0;
    for (int g = 0; g < 6; g++) begin
      wait_req(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL burst_grant%0d: got no o_mem_req want 1", g); end
      n_cmp++; if ((bus.o_mem_addr == 32'h3000) !== exp_d[g]) begin n_bad++; $display("FAIL burst_kind%0d: got addr %h want data=%b", g, bus.o_mem_addr, exp_d[g]); end
      respond(32'h100 + 32'(g));
      n_cmp++; if ({bus.o_data_ack, bus.o_inst_ack} !== {exp_d[g], ~exp_d[g]}) begin n_bad++; $display("FAIL burst_ack%0d: got %b want %b", g, {bus.o_data_ack, bus.o_inst_ack}, {exp_d[g], ~exp_d[g]}); end
    end
    n_cmp++; if (bus.o_data_rdata !== 32'h105) begin n_bad++; $display("FAIL burst_rdata: got %h want 00000105", bus.o_data_rdata); end
    bus.i_inst_req = 1'b0; bus.i_data_req = 1'b0;
    cyc(2);
  endtask

  task automatic test_timeout;
    bit ok;
    int n;
    bus.i_data_req = 1'b1; bus.i_data_addr = 32'h5000; bus.i_data_rw = 1'b0;
    wait_req(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_grant: got no o_mem_req want 1"); end
    n = 0;
    while (bus.o_mem_req && n < 50) begin
      n++;
      @(negedge clk);
    end
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL to_busy_cycles: got %0d want 8", n); end
    n_cmp++; if ({bus.o_data_ack, bus.o_data_err, bus.o_inst_ack} !== 3'b110) begin n_bad++; $display("FAIL to_ack_err: got %b want 110", {bus.o_data_ack, bus.o_data_err, bus.o_inst_ack}); end
    n_cmp++; if (bus.o_data_rdata !== 32'h0) begin n_bad++; $display("FAIL to_rdata: got %h want 0", bus.o_data_rdata); end
    bus.i_data_req = 1'b0;
    cyc(1);
    n_cmp++; if ({bus.o_data_ack, bus.o_data_err} !== 2'b00) begin n_bad++; $display("FAIL to_pulse: got %b want 00", {bus.o_data_ack, bus.o_data_err}); end
    cyc(1);
  endtask

  task automatic test_timeout_tie;
    bit ok;
    bus.i_data_req = 1'b1; bus.i_data_addr = 32'h5004;
    wait_req(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL tie_grant: got no o_mem_req want 1"); end
    cyc(7);
    n_cmp++; if (bus.o_mem_req !== 1'b1) begin n_bad++; $display("FAIL tie_still_busy: got %b want 1", bus.o_mem_req); end
    respond(32'h7777_0001);
    n_cmp++; if ({bus.o_data_ack, bus.o_data_err} !== 2'b10) begin n_bad++; $display("FAIL tie_ack_err: got %b want 10", {bus.o_data_ack, bus.o_data_err}); end
    n_cmp++; if (bus.o_data_rdata !== 32'h7777_0001) begin n_bad++; $display("FAIL tie_rdata: got %h want 77770001", bus.o_data_rdata); end
    bus.i_data_req = 1'b0;
    cyc(2);
  endtask

  task automatic test_stability_drop;
    bit ok;
    logic [67:0] exp_f;
    bus.i_data_req = 1'b1; bus.i_data_addr = 32'h7000; bus.i_data_wdata = 32'h1122_3344;
    bus.i_data_funct3 = 3'b001; bus.i_data_rw = 1'b1;
    exp_f = {32'h7000, 32'h1122_3344, 3'b001, 1'b1};
    wait_req(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stab_grant: got no o_mem_req want 1"); end
    for (int i = 0; i < 3; i++) begin
      bus.i_data_addr = 32'h9000 + 32'(i); bus.i_data_wdata = ~bus.i_data_wdata;
      bus.i_data_funct3 = 3'(i + 4); bus.i_data_rw = ~bus.i_data_rw;
      cyc(1);
      n_cmp++; if ({bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_funct3, bus.o_mem_rw} !== exp_f) begin n_bad++; $display("FAIL stab_fields%0d: got %h want %h", i, {bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_funct3, bus.o_mem_rw}, exp_f); end
    end
    bus.i_data_req = 1'b0;
    cyc(1);
    n_cmp++; if (bus.o_mem_req !== 1'b1) begin n_bad++; $display("FAIL drop_still_busy: got %b want 1", bus.o_mem_req); end
    respond(32'hCAFE_0001);
    n_cmp++; if ({bus.o_data_ack, bus.o_data_err, bus.o_mem_req} !== 3'b100) begin n_bad++; $display("FAIL drop_ack: got %b want 100", {bus.o_data_ack, bus.o_data_err, bus.o_mem_req}); end
    n_cmp++; if (bus.o_data_rdata !== 32'hCAFE_0001) begin n_bad++; $display("FAIL drop_rdata: got %h want cafe0001", bus.o_data_rdata); end
    cyc(1);
    n_cmp++; if ({bus.o_data_ack, bus.o_mem_req} !== 2'b00) begin n_bad++; $display("FAIL drop_once: got %b want 00", {bus.o_data_ack, bus.o_mem_req}); end
    cyc(1);
  endtask

  task automatic test_reset_mid;
    bit ok;
    bus.i_data_req = 1'b1; bus.i_data_addr = 32'h8000; bus.i_data_rw = 1'b0;
    wait_req(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_grant: got no o_mem_req want 1"); end
    cyc(1);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.o_mem_req, bus.o_data_ack, bus.o_inst_ack} !== 3'b000) begin n_bad++; $display("FAIL rmid_async: got %b want 000", {bus.o_mem_req, bus.o_data_ack, bus.o_inst_ack}); end
    n_cmp++; if ({bus.o_mem_addr, bus.o_data_rdata} !== 64'h0) begin n_bad++; $display("FAIL rmid_regs: got %h want 0", {bus.o_mem_addr, bus.o_data_rdata}); end
    bus.i_data_req = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    respond(32'hBAD0_BAD0);
    n_cmp++; if ({bus.o_mem_req, bus.o_data_ack, bus.o_inst_ack} !== 3'b000) begin n_bad++; $display("FAIL rmid_late_ack: got %b want 000", {bus.o_mem_req, bus.o_data_ack, bus.o_inst_ack}); end
    bus.i_inst_req = 1'b1; bus.i_inst_addr = 32'h600;
    wait_req(ok);
    n_cmp++; if (!ok || bus.o_mem_addr !== 32'h600) begin n_bad++; $display("FAIL rmid_next_grant: got req=%b addr=%h want req=1 addr=00000600", ok, bus.o_mem_addr); end
    respond(32'h0000_6006);
    n_cmp++; if ({bus.o_inst_ack, bus.o_inst_err, bus.o_inst_data} !== {2'b10, 32'h6006}) begin n_bad++; $display("FAIL rmid_next_ack: got %h want %h", {bus.o_inst_ack, bus.o_inst_err, bus.o_inst_data}, {2'b10, 32'h6006}); end
    bus.i_inst_req = 1'b0;
    cyc(2);
  endtask

  initial begin
    bus.i_inst_req = 1'b0; bus.i_inst_addr = '0;
    bus.i_data_req = 1'b0; bus.i_data_addr = '0; bus.i_data_wdata = '0;
    bus.i_data_funct3 = '0; bus.i_data_rw = 1'b0;
    bus.i_mem_ack = 1'b0; bus.i_mem_rdata = '0;
    test_reset;
    test_ack_idle;
    test_single_fetch;
    test_simultaneous;
    test_burst;
    test_timeout;
    test_timeout_tie;
    test_stability_drop;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
